// File: rtl/fft_spi_pkg.sv
// Shared FSM state type and default frame/clock constants for the FFT SPI controller.
package fft_spi_pkg;

  localparam int FFT_FRAME_BITS   = 4096;
  localparam int FFT_SPI_HALF_DIV = 4;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    SHIFT,
    TAIL,
    DONE
  } spi_state_t;

endpackage

// File: rtl/spi_clk_div.sv
// SPI clock divider: sck toggles every HALF_DIV enabled cycles, first toggle is a rise.
// rise/fall strobe in the cycle before sck changes; disabled divider holds sck low.
module spi_clk_div
  import fft_spi_pkg::*;
#(
  parameter int HALF_DIV = FFT_SPI_HALF_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic sck,
  output logic rise,
  output logic fall
);

  localparam int              CW   = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam logic [CW-1:0]   LAST = CW'(HALF_DIV - 1);

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap = en && (cnt == LAST);
  assign rise = wrap && !sck;
  assign fall = wrap && sck;

  always_ff @(posedge clk) begin
    if (reset || !en) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (cnt == LAST) begin
      cnt <= '0;
      sck <= ~sck;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fft_spi_ctrl.sv
// Mode-0 SPI frame controller: LEAD, FRAME_BITS sck pulses, TAIL, one-cycle done.
// Define FFT_SPI_CTRL_LOOPBACK_EN to sample copi instead of the cipo pin.
module fft_spi_ctrl
  import fft_spi_pkg::*;
#(
  parameter int FRAME_BITS = FFT_FRAME_BITS,
  parameter int HALF_DIV   = FFT_SPI_HALF_DIV
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] tx_frame,
  output logic [FRAME_BITS-1:0] rx_frame,
  output logic                  busy,
  output logic                  done,
  output logic                  sck,
  output logic                  cs_n,
  output logic                  copi,
  input  logic                  cipo
);

  localparam int            BW       = $clog2(FRAME_BITS) + 1;
  localparam int            HW       = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS);
  localparam logic [HW-1:0] H_LAST   = HW'(HALF_DIV - 1);

  spi_state_t            state, state_nxt;
  logic [FRAME_BITS-1:0] tx_sr;
  logic [FRAME_BITS-1:0] rx_sr;
  logic [BW-1:0]         bit_cnt;
  logic [HW-1:0]         hcnt;
  logic                  sck_rise;
  logic                  sck_fall;
  logic                  sample_bit;
  logic                  in_frame;

`ifdef FFT_SPI_CTRL_LOOPBACK_EN
  logic unused_cipo;
  assign unused_cipo = cipo;
  assign sample_bit  = copi;
`else
  assign sample_bit  = cipo;
`endif

  assign in_frame = (state == LEAD) || (state == SHIFT) || (state == TAIL);
  assign busy     = in_frame;
  assign cs_n     = !in_frame;
  assign done     = (state == DONE);
  assign copi     = in_frame && tx_sr[FRAME_BITS-1];

  spi_clk_div #(
    .HALF_DIV (HALF_DIV)
  ) u_clk_div (
    .clk   (clk),
    .reset (reset),
    .en    (state == SHIFT),
    .sck   (sck),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LEAD;
      LEAD:    if (hcnt == H_LAST) state_nxt = SHIFT;
      // the fall after the last rise closes the high hold of the final bit
      SHIFT:   if (sck_fall && (bit_cnt == BIT_LAST)) state_nxt = TAIL;
      TAIL:    if (hcnt == H_LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_sr    <= '0;
      rx_sr    <= '0;
      rx_frame <= '0;
      bit_cnt  <= '0;
      hcnt     <= '0;
    end else begin
      if (((state == LEAD) || (state == TAIL)) && (hcnt != H_LAST)) begin
        hcnt <= hcnt + 1'b1;
      end else begin
        hcnt <= '0;
      end

      case (state)
        IDLE: begin
          if (start) begin
            tx_sr   <= tx_frame;
            rx_sr   <= '0;
            bit_cnt <= '0;
          end
        end
        SHIFT: begin
          if (sck_rise) begin
            rx_sr   <= {rx_sr[FRAME_BITS-2:0], sample_bit};
            bit_cnt <= bit_cnt + 1'b1;
          end
          if (sck_fall) begin
            tx_sr <= {tx_sr[FRAME_BITS-2:0], 1'b0};
          end
        end
        TAIL: begin
          if (hcnt == H_LAST) rx_frame <= rx_sr;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_spi_ctrl.sv
// Directed bench with a scoreboard of expected tx/rx frames and a cipo peripheral model.
module tb_fft_spi_ctrl;

`ifdef FFT_SPI_CTRL_LOOPBACK_EN
  localparam int FB = 4096;
`else
  localparam int FB = 16;
`endif
  localparam int HD  = 2;
  localparam int LAT = (2*FB + 2)*HD + 1;
  localparam int PW  = (FB < 64) ? FB : 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [FB-1:0] tx_frame;
  logic [FB-1:0] rx_frame;
  logic          busy, done, sck, cs_n, copi;
  logic          cipo = 1'b0;

  fft_spi_ctrl #(.FRAME_BITS(FB), .HALF_DIV(HD)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .tx_frame (tx_frame),
    .rx_frame (rx_frame),
    .busy     (busy),
    .done     (done),
    .sck      (sck),
    .cs_n     (cs_n),
    .copi     (copi),
    .cipo     (cipo)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int rise_cnt    = 0;
  int bit_idx     = 0;
  int done_cnt    = 0;
  int csfall_cnt  = 0;
  logic          sck_prev = 1'b0;
  logic          cs_prev  = 1'b1;
  logic [FB-1:0] periph_sr   = '0;
  logic [FB-1:0] periph_resp = '0;
  logic [FB-1:0] tx_q[$];
  logic [FB-1:0] rx_q[$];

  task automatic chk(input string tag, input logic [FB-1:0] obs, input logic [FB-1:0] exp);
    logic [PW-1:0] o, e;
    o = obs[PW-1:0];
    e = exp[PW-1:0];
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  // Monitor and peripheral model share one process so the counters have a single writer.
  always @(negedge clk) begin
    logic [FB-1:0] t;
    if (reset) begin
      rise_cnt = 0;
      bit_idx  = 0;
      tx_q.delete();
      rx_q.delete();
    end else begin
      if (sck && !sck_prev) begin
        rise_cnt++;
        if (tx_q.size() != 0 && bit_idx < FB) begin
          t = tx_q[0];
          chk("copi_bit", FB'(copi), FB'(t[FB-1-bit_idx]));
        end
        bit_idx++;
      end
      if (done) begin
        done_cnt++;
        chk("rise_count", FB'(rise_cnt), FB'(FB));
        chk("sb_pending", FB'(rx_q.size() != 0), FB'(1));
        if (rx_q.size() != 0) begin
          chk("rx_frame", rx_frame, rx_q.pop_front());
          void'(tx_q.pop_front());
        end
        rise_cnt = 0;
        bit_idx  = 0;
      end
    end
    if (!cs_n && cs_prev) begin
      csfall_cnt++;
      periph_sr = periph_resp;
    end else if (!sck && sck_prev && !cs_n) begin
      periph_sr = periph_sr << 1;
    end
`ifdef FFT_SPI_CTRL_LOOPBACK_EN
    cipo = 1'($urandom);
`else
    cipo = periph_sr[FB-1];
`endif
    sck_prev = sck;
    cs_prev  = cs_n;
  end

  function automatic logic [FB-1:0] exp_rx(input logic [FB-1:0] tx, input logic [FB-1:0] resp);
`ifdef FFT_SPI_CTRL_LOOPBACK_EN
    exp_rx = tx;
    if (resp == '1) exp_rx = tx;
`else
    exp_rx = resp;
    if (tx == '1) exp_rx = resp;
`endif
  endfunction

  task automatic run_frame(input logic [FB-1:0] tx, input logic [FB-1:0] resp, output int lat);
    @(negedge clk);
    periph_resp = resp;
    tx_frame    = tx;
    start       = 1'b1;
    tx_q.push_back(tx);
    rx_q.push_back(exp_rx(tx, resp));
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    while (!done && lat < LAT + 50) begin
      @(negedge clk);
      lat++;
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $error("FAIL done_timeout: observed no done after %0d cycles, expected done at %0d", lat, LAT);
    end
  endtask

  initial begin
    logic [FB-1:0] basic_tx, basic_resp;
    int lat, d0, c0, n;
`ifdef FFT_SPI_CTRL_LOOPBACK_EN
    basic_tx   = {(FB/8){8'h5A}};
    basic_resp = '0;
`else
    basic_tx   = FB'(16'hA5C3);
    basic_resp = FB'(16'h3C5A);
`endif
    reset    = 1'b1;
    start    = 1'b0;
    tx_frame = '0;
    repeat (3) @(negedge clk);
    chk("rst_sck",  FB'(sck),  FB'(0));
    chk("rst_cs_n", FB'(cs_n), FB'(1));
    chk("rst_copi", FB'(copi), FB'(0));
    chk("rst_busy", FB'(busy), FB'(0));
    chk("rst_done", FB'(done), FB'(0));
    chk("rst_rx",   rx_frame,  FB'(0));
    reset = 1'b0;

    // idle levels {sck,cs_n,busy,done,copi}
    repeat (100) begin
      @(negedge clk);
      chk("idle_levels", FB'({sck, cs_n, busy, done, copi}), FB'(5'b01000));
    end

    // reset wins over start
    @(negedge clk);
    reset    = 1'b1;
    start    = 1'b1;
    tx_frame = '1;
    @(negedge clk);
    chk("prio_busy", FB'(busy), FB'(0));
    chk("prio_cs_n", FB'(cs_n), FB'(1));
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("prio_busy_after", FB'(busy), FB'(0));

    // basic frame
    run_frame(basic_tx, basic_resp, lat);
    chk("latency", FB'(lat), FB'(LAT));
    @(negedge clk);
    chk("done_width", FB'(done), FB'(0));

    // start held high for the whole frame, including the DONE cycle
    d0 = done_cnt;
    c0 = csfall_cnt;
    @(negedge clk);
    periph_resp = FB'(16'hBEEF);
    tx_frame    = FB'(16'h1357);
    start       = 1'b1;
    tx_q.push_back(FB'(16'h1357));
    rx_q.push_back(exp_rx(FB'(16'h1357), FB'(16'hBEEF)));
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < LAT + 50);
    chk("busy_done_seen", FB'(done), FB'(1));
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    chk("busy_one_done", FB'(done_cnt - d0), FB'(1));
    chk("busy_one_cs",   FB'(csfall_cnt - c0), FB'(1));
    chk("busy_idle",     FB'(busy), FB'(0));

    // reset during bit 7
    @(negedge clk);
    periph_resp = FB'(16'h0F0F);
    tx_frame    = FB'(16'hC3C3);
    start       = 1'b1;
    tx_q.push_back(FB'(16'hC3C3));
    rx_q.push_back(exp_rx(FB'(16'hC3C3), FB'(16'h0F0F)));
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (rise_cnt < 7 && n < LAT) begin
      @(negedge clk);
      n++;
    end
    chk("mid_reached_bit7", FB'(rise_cnt >= 7), FB'(1));
    d0 = done_cnt;
    reset = 1'b1;
    @(negedge clk);
    chk("mid_cs_n", FB'(cs_n), FB'(1));
    chk("mid_sck",  FB'(sck),  FB'(0));
    chk("mid_copi", FB'(copi), FB'(0));
    chk("mid_rx",   rx_frame,  FB'(0));
    chk("mid_busy", FB'(busy), FB'(0));
    reset = 1'b0;
    repeat (200) @(negedge clk);
    chk("mid_no_done", FB'(done_cnt - d0), FB'(0));

    // back-to-back: second start in the IDLE cycle right after done
    run_frame('1, FB'(16'h1234), lat);
    chk("b2b_lat0", FB'(lat), FB'(LAT));
    run_frame(FB'(1), FB'(16'h8001), lat);
    chk("b2b_lat1", FB'(lat), FB'(LAT));
    repeat (10) @(negedge clk);
    chk("sb_drained", FB'(rx_q.size()), FB'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
